// File: rtl/skid_fifo_pkg.sv
// Shared types and helpers for skid_fifo.
//   skid_st_t : occupancy state, re-derived each cycle from the next level
//   MIN_DEPTH / MAX_DEPTH : legal range of the DEPTH parameter
//   ptr_next  : ring pointer increment with explicit wrap (ring size need not be 2^n)
package skid_fifo_pkg;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_st_t;

  localparam int unsigned MIN_DEPTH = 2;
  localparam int unsigned MAX_DEPTH = 256;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned size);
    return (ptr + 1 >= size) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/skid_fifo_ram.sv
// Skid storage ring for skid_fifo: ENTRIES x WIDTH flop array.
// Registered write, asynchronous read. Kept separate so it can be swapped for a
// latch array or SRAM macro without touching the control logic.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module skid_fifo_ram #(
  parameter int unsigned ENTRIES = 3,
  parameter int unsigned WIDTH   = 9,
  localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  // Storage carries no reset: contents are only read once the level says valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/skid_fifo.sv
// skid_fifo: elastic valid/ready pipeline stage. A registered output stage plus a
// ring of DEPTH-1 skid entries; s_ready and m_valid both come straight from flops.
// Optional build macro SKID_FIFO_PKT_CNT_EN adds the pkt_count output.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   flush           synchronous discard of all contents (highest priority)
//   s_valid/s_ready upstream handshake (s_ready registered)
//   s_data/s_last   upstream payload and end-of-packet marker
//   m_valid/m_ready downstream handshake (m_valid registered)
//   m_data/m_last   registered head-of-queue payload and marker
//   level           registered count of stored words, 0..DEPTH
//   pkt_count       (SKID_FIFO_PKT_CNT_EN only) stored words carrying last
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [LW-1:0]         level
`ifdef SKID_FIFO_PKT_CNT_EN
  ,
  output logic [LW-1:0]         pkt_count
`endif
);

  localparam int unsigned RING = DEPTH - 1;
  localparam int unsigned PW   = (RING > 1) ? $clog2(RING) : 1;

  if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : gen_depth_check
    $error("skid_fifo: DEPTH must be within 2..256");
  end

  logic [LW-1:0]         level_q, level_d, next_level;
  skid_st_t              state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [WORD_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  logic                  push, pop;
  logic                  ring_empty, out_empty;
  logic                  direct_load, ring_load, ring_we;
  logic [WORD_WIDTH:0]   ring_rdata;

  always_comb begin
    push       = s_valid & s_ready_q;
    pop        = m_valid_q & m_ready;
    next_level = level_q + LW'(push) - LW'(pop);

    // Output register holds one word whenever level != 0, so the ring holds level-1.
    out_empty  = (state_q == EMPTY);
    ring_empty = (level_q <= LW'(1));

    // Bypass the ring only when nothing older can be waiting in it.
    direct_load = push & (out_empty | (pop & ring_empty));
    ring_load   = pop & ~ring_empty;
    ring_we     = push & ~direct_load & ~flush;

    m_data_d = m_data_q;
    m_last_d = m_last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = next_level;

    if (flush) begin
      // Contents discarded; m_data keeps its stale value.
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (direct_load) begin
        m_data_d = s_data;
        m_last_d = s_last;
      end else if (ring_load) begin
        m_data_d = ring_rdata[WORD_WIDTH-1:0];
        m_last_d = ring_rdata[WORD_WIDTH];
      end
      if (ring_we) begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), RING));
      end
      if (ring_load) begin
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), RING));
      end
    end

    // Handshake flops look ahead at the next level, so no overflow despite registering.
    s_ready_d = (level_d < LW'(DEPTH));
    m_valid_d = (level_d != '0);

    if (level_d == '0) begin
      state_d = EMPTY;
    end else if (level_d == LW'(DEPTH)) begin
      state_d = FULL;
    end else begin
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q   <= '0;
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      level_q   <= level_d;
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  skid_fifo_ram #(
    .ENTRIES (RING),
    .WIDTH   (WORD_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ring_we),
    .waddr (wr_ptr_q),
    .wdata ({s_last, s_data}),
    .raddr (rd_ptr_q),
    .rdata (ring_rdata)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign level   = level_q;

`ifdef SKID_FIFO_PKT_CNT_EN
  logic [LW-1:0] pkt_q, pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (flush) begin
      pkt_d = '0;
    end else begin
      pkt_d = pkt_q + LW'(push & s_last) - LW'(pop & m_last_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Bench for skid_fifo (WORD_WIDTH=8, DEPTH=4): queue model checked every cycle,
// plus directed literal expectations along the test plan.
module tb_skid_fifo;
  import skid_fifo_pkg::*;

  localparam int unsigned WORD_WIDTH = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned LW         = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rstn;
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic [WORD_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [WORD_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [LW-1:0]         level;
`ifdef SKID_FIFO_PKT_CNT_EN
  logic [LW-1:0]         pkt_count;
`endif

  int n_vec;
  int n_bad;

  skid_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .level   (level)
`ifdef SKID_FIFO_PKT_CNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain queue of {last, data}; the head is what m_data must show.
  logic [WORD_WIDTH:0] mq[$];

  always @(posedge clk or negedge rstn) begin : model
    bit p_push, p_pop;
    if (!rstn) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      p_pop  = (mq.size() != 0) && m_ready;
      p_push = s_valid && (mq.size() < DEPTH);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back({s_last, s_data});
    end
  end

  always @(negedge clk) begin : compare
    int nl;
    if (rstn === 1'b1) begin
      check("model s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
      check("model m_valid", 32'(m_valid), 32'(mq.size() != 0));
      check("model level", 32'(level), 32'(mq.size()));
      if (mq.size() != 0) begin
        check("model m_data", 32'(m_data), 32'(mq[0][WORD_WIDTH-1:0]));
        check("model m_last", 32'(m_last), 32'(mq[0][WORD_WIDTH]));
      end
`ifdef SKID_FIFO_PKT_CNT_EN
      nl = 0;
      foreach (mq[i]) nl += int'(mq[i][WORD_WIDTH]);
      check("model pkt_count", 32'(pkt_count), 32'(nl));
`endif
    end
  end

  // Drive one cycle's inputs at a falling edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = r;
    @(negedge clk);
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset s_ready", 32'(s_ready), 32'd1);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset level", 32'(level), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset m_last", 32'(m_last), 32'd0);
    check("reset state", 32'(dut.state_q), 32'(EMPTY));
    rstn = 1'b1;
    @(negedge clk);

    // Backpressure fill.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill m_data", 32'(m_data), 32'h01);
      check("fill level", 32'(level), 32'(i));
    end
    check("fill s_ready", 32'(s_ready), 32'd0);
    check("fill state", 32'(dut.state_q), 32'(FULL));

    // Drain order.
    for (int i = 0; i < 4; i++) begin
      check("drain m_data", 32'(m_data), 32'(i + 1));
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      if (i == 0) check("drain s_ready", 32'(s_ready), 32'd1);
    end
    check("drain m_valid", 32'(m_valid), 32'd0);

    // Full-rate streaming.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b1);
      check("stream m_data", 32'(m_data), 32'(i));
      check("stream level", 32'(level), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("stream drained", 32'(m_valid), 32'd0);

    // Simultaneous push/pop at level 2, across ring wrap.
    cyc(1'b1, 8'h30, 1'b0, 1'b0);
    cyc(1'b1, 8'h31, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("wrap m_data", 32'(m_data), 32'(8'h30 + i));
      cyc(1'b1, 8'(8'h32 + i), 1'(i % 2), 1'b1);
      check("wrap level", 32'(level), 32'd2);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap drained", 32'(level), 32'd0);

    // Reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("prereset level", 32'(level), 32'd3);
    s_valid = 1'b0;
    rstn    = 1'b0;
    #1;
    check("async m_valid", 32'(m_valid), 32'd0);
    check("async s_ready", 32'(s_ready), 32'd1);
    check("async level", 32'(level), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    check("post-reset m_valid", 32'(m_valid), 32'd1);
    check("post-reset m_data", 32'(m_data), 32'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush with a push in the same cycle.
    cyc(1'b1, 8'hA0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b1, 1'b0);
    cyc(1'b1, 8'hB0, 1'b1, 1'b0);
    check("preflush level", 32'(level), 32'd3);
`ifdef SKID_FIFO_PKT_CNT_EN
    check("preflush pkt_count", 32'(pkt_count), 32'd2);
`endif
    flush = 1'b1;
    cyc(1'b1, 8'hC0, 1'b1, 1'b1);
    flush = 1'b0;
    check("flush level", 32'(level), 32'd0);
    check("flush m_valid", 32'(m_valid), 32'd0);
    check("flush s_ready", 32'(s_ready), 32'd1);
`ifdef SKID_FIFO_PKT_CNT_EN
    check("flush pkt_count", 32'(pkt_count), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("postflush m_valid", 32'(m_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
